unary_stream_decoder: RTL and testbench
=======================================

// Module: unary_stream_decoder
// PURPOSE
//  Receive-side counterpart of Product_Block. Consumes its serial unary
//  product stream (out = one 1 per unit, done = end of stream) and turns it
//  back into a binary count. Presents the count to downstream logic over a
//  valid/ready handshake. One stream can accumulate while the previous
//  result waits to be taken.
// PARAMETERS
//  COUNT_W   8   width of accumulator/result (4b x 4b max product 225 fits)
// PORTS
//  clk           in   1        single clock, all logic on posedge
//  reset         in   1        synchronous, active-high
//  in_bit        in   1        unary stream bit (Product_Block out)
//  in_done       in   1        end-of-stream strobe (Product_Block done)
//  result_ready  in   1        downstream accepts result this cycle
//  result        out  COUNT_W  decoded count of the held stream
//  result_valid  out  1        result/result_ovf hold a valid value
//  result_ovf    out  1        held result saturated during accumulation
//  busy          out  1        >=1 in_bit seen since last accepted in_done
//  drop_err      out  1        sticky: a completed stream was discarded
// BEHAVIOUR
//  - Reset (sync, any cycle incl. mid-stream): acc=0, acc_ovf=0, busy=0,
//    result=0, result_valid=0, result_ovf=0, drop_err=0. Partial stream lost.
//  - Two registers: acc (counting stage), result (holding stage).
//  - Each cycle in_bit=1: acc <= acc+1; at 2^COUNT_W-1 acc holds and acc_ovf<=1.
//  - in_done sampled high = end of stream; in_bit on same cycle IS counted.
//    Final value f = sat(acc + in_bit); ovf_f = acc_ovf | (in_bit & acc==max).
//  - take = result_valid & result_ready (handshake completes this edge).
//  - Holding stage free = ~result_valid | take.
//  - in_done & free: result<=f, result_ovf<=ovf_f, result_valid<=1 next cycle
//    (latency 1 clk from in_done edge to result_valid); acc<=0, acc_ovf<=0.
//  - in_done & ~free: stream discarded, acc<=0, acc_ovf<=0, drop_err<=1
//    (sticky until reset); held result unchanged.
//  - take & ~in_done: result_valid<=0; result/result_ovf keep old value.
//  - take & in_done same cycle: new result loaded, result_valid stays 1.
//  - result/result_ovf stable while result_valid & ~result_ready.
//  - in_done with no preceding in_bit: valid zero-length stream, result=0.
//  - in_bit while result_valid: accumulates normally (next stream overlaps).
//  - busy = registered: set on in_bit, cleared on in_done (in_done wins).
//  - FSM (holding stage): EMPTY -> FULL on in_done; FULL -> EMPTY on take
//    w/o in_done; FULL -> FULL on take+in_done or wait; drop in FULL w/o take.
// TESTING
//  1 reset; 6 cycles in_bit=1, in_done on 6th, result_ready=1 -> next clk
//    result=6, result_valid=1 for 1 clk, result_ovf=0, busy back to 0.
//  2 stream of 15 ones with 20 idle cycles mid-stream, ready=1 -> result=15.
//  3 ready=0; stream 6 done, then stream 15 done -> result stays 6,
//    drop_err=1; raise ready -> take 6, result_valid falls next clk.
//  4 ready=0 stream 6 done; ready=1 on same clk as stream 15 in_done ->
//    result_valid stays 1, result=15, drop_err=0.
//  5 COUNT_W=4, 20 ones then done -> result=15, result_ovf=1; next stream of
//    3 -> result=3, result_ovf=0.
//  6 reset asserted after 4 ones of a stream -> all outputs 0; then 2 ones +
//    done -> result=2 (no residue); in_done alone -> result=0, valid=1.

Source files
------------

// File: rtl/unary_stream_decoder.sv
// Turns a serial unary stream (one in_bit per unit, in_done at the end) back into a
// binary count. The count is handed downstream over valid/ready, one result deep.
//
// state | meaning
// ------+------------------------------------------------------
// EMPTY | holding stage has no result; a finished stream loads
// FULL  | result held until taken; a finished stream w/o take drops
module unary_stream_decoder #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_bit,
  input  logic               in_done,
  input  logic               result_ready,
  output logic [COUNT_W-1:0] result,
  output logic               result_valid,
  output logic               result_ovf,
  output logic               busy,
  output logic               drop_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state;
  state_t             state_next;
  logic [COUNT_W-1:0] acc;
  logic               acc_ovf;
  logic               acc_max;
  logic [COUNT_W-1:0] final_cnt;
  logic               final_ovf;
  logic               take;
  logic               free;
  logic               load;
  logic               drop;

  // The bit arriving alongside in_done still belongs to the stream.
  assign acc_max   = &acc;
  assign final_cnt = (in_bit && !acc_max) ? acc + COUNT_W'(1) : acc;
  assign final_ovf = acc_ovf | (in_bit & acc_max);

  assign take = (state == FULL) && result_ready;
  assign free = (state == EMPTY) || take;
  assign load = in_done && free;
  assign drop = in_done && !free;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (in_done)          state_next = FULL;
      FULL:    if (take && !in_done) state_next = EMPTY;
      default:                       state_next = EMPTY;
    endcase
  end

  always_comb begin
    result_valid = (state == FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      acc_ovf    <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      result_ovf <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      if (in_done) begin
        acc     <= '0;
        acc_ovf <= 1'b0;
      end else if (in_bit) begin
        acc     <= final_cnt;
        acc_ovf <= final_ovf;
      end

      if (in_done)     busy <= 1'b0;
      else if (in_bit) busy <= 1'b1;

      if (load) begin
        result     <= final_cnt;
        result_ovf <= final_ovf;
      end

      if (drop) drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Directed bench for unary_stream_decoder: an 8-bit and a 4-bit instance share
// the same stimulus; the 4-bit one exercises accumulator saturation.
module tb_unary_stream_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_bit;
  logic       in_done;
  logic       result_ready;

  logic [7:0] result8;
  logic       valid8, ovf8, busy8, drop8;
  logic [3:0] result4;
  logic       valid4, ovf4, busy4, drop4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unary_stream_decoder #(.COUNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_done(in_done),
    .result_ready(result_ready), .result(result8), .result_valid(valid8),
    .result_ovf(ovf8), .busy(busy8), .drop_err(drop8)
  );

  unary_stream_decoder #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_done(in_done),
    .result_ready(result_ready), .result(result4), .result_valid(valid4),
    .result_ovf(ovf4), .busy(busy4), .drop_err(drop4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge, so samples land mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_bit = 1'b0; in_done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) begin
      in_bit = 1'b1; in_done = 1'b0;
      tick();
    end
    in_bit = 1'b0;
  endtask

  // n ones with in_done on the last; n==0 gives a lone in_done
  task automatic stream(input int n);
    if (n == 0) begin
      in_bit = 1'b0; in_done = 1'b1;
      tick();
    end else begin
      for (int i = 0; i < n; i++) begin
        in_bit = 1'b1; in_done = (i == n - 1);
        tick();
      end
    end
    in_bit = 1'b0; in_done = 1'b0;
  endtask

  task automatic check_zero8(input string tag);
    check({tag, "_result"}, result8, 0);
    check({tag, "_valid"},  valid8,  0);
    check({tag, "_ovf"},    ovf8,    0);
    check({tag, "_busy"},   busy8,   0);
    check({tag, "_drop"},   drop8,   0);
  endtask

  initial begin
    reset = 1'b1; in_bit = 1'b0; in_done = 1'b0; result_ready = 1'b0;
    #2;

    // 1: six ones, done on the sixth
    do_reset();
    check_zero8("t1_reset");
    result_ready = 1'b1;
    ones(3);
    check("t1_busy_mid", busy8, 1);
    ones(2);
    stream(1);
    check("t1_result", result8, 6);
    check("t1_valid",  valid8,  1);
    check("t1_ovf",    ovf8,    0);
    check("t1_busy",   busy8,   0);
    tick();
    check("t1_valid_fall", valid8, 0);
    check("t1_result_kept", result8, 6);

    // 2: 15 ones with a 20-cycle gap, then a lone done
    ones(7);
    for (int i = 0; i < 20; i++) tick();
    check("t2_busy_gap", busy8, 1);
    check("t2_valid_gap", valid8, 0);
    ones(8);
    stream(0);
    check("t2_result", result8, 15);
    check("t2_valid",  valid8,  1);
    tick();

    // 3: second stream dropped while holding stage is full
    do_reset();
    result_ready = 1'b0;
    stream(6);
    check("t3_first", result8, 6);
    stream(15);
    check("t3_held",  result8, 6);
    check("t3_valid", valid8,  1);
    check("t3_drop",  drop8,   1);
    tick();
    check("t3_still_valid", valid8, 1);
    result_ready = 1'b1;
    tick();
    check("t3_valid_fall", valid8, 0);
    check("t3_result_kept", result8, 6);
    check("t3_drop_sticky", drop8, 1);

    // 4: take and load on the same edge
    do_reset();
    result_ready = 1'b0;
    stream(6);
    ones(14);
    check("t4_held", result8, 6);
    result_ready = 1'b1;
    stream(1);
    check("t4_result", result8, 15);
    check("t4_valid",  valid8,  1);
    check("t4_drop",   drop8,   0);
    tick();
    check("t4_valid_fall", valid8, 0);

    // 5: 4-bit saturation
    do_reset();
    result_ready = 1'b1;
    stream(20);
    check("t5_result4", result4, 15);
    check("t5_ovf4",    ovf4,    1);
    check("t5_result8", result8, 20);
    check("t5_ovf8",    ovf8,    0);
    stream(3);
    check("t5_next_result4", result4, 3);
    check("t5_next_ovf4",    ovf4,    0);
    stream(15);
    check("t5_edge_result4", result4, 15);
    check("t5_edge_ovf4",    ovf4,    0);
    stream(16);
    check("t5_edge1_ovf4",   ovf4,    1);
    tick();

    // 6: reset mid-stream leaves no residue
    do_reset();
    result_ready = 1'b1;
    ones(4);
    check("t6_busy", busy8, 1);
    do_reset();
    check_zero8("t6_reset");
    stream(2);
    check("t6_result", result8, 2);
    check("t6_valid",  valid8,  1);
    tick();
    stream(0);
    check("t6_empty_result", result8, 0);
    check("t6_empty_valid",  valid8,  1);
    check("t6_empty_ovf",    ovf8,    0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
